// File: rtl/mod_n_pkg.sv
// Shared helpers for the mod-N stream checker: remainder width and the
// reference step rule used to advance a remainder by one serial bit.
package mod_n_pkg;

  function automatic int rem_width(input int divisor);
    return $clog2(divisor);
  endfunction

  // t = 2*rem + din is always below 2*divisor, so one conditional subtract reduces it.
  function automatic int unsigned mod_step(input int unsigned rem, input logic din,
                                           input int unsigned divisor);
    int unsigned t;
    t = (rem << 1) + 32'(din);
    return (t >= divisor) ? t - divisor : t;
  endfunction

endpackage

// File: rtl/mod_n_lane.sv
// One lane of the mod-N checker: keeps the running value mod DIVISOR of an
// MSB-first serial stream and flags divisibility once a bit has been absorbed.
module mod_n_lane
  import mod_n_pkg::*;
#(
  parameter  int DIVISOR = 5,
  localparam int RW      = rem_width(DIVISOR)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          din_valid,
  input  logic          din,
  input  logic          start,
  output logic          dout,
  output logic [RW-1:0] rem,
  output logic          active
);

  localparam logic [RW:0] DIV_W = (RW+1)'(DIVISOR);

  logic [RW-1:0] r_rem;
  logic          r_active;
  logic [RW:0]   w_t;
  logic [RW-1:0] w_next;

  assign w_t    = {r_rem, din};
  assign w_next = (w_t >= DIV_W) ? RW'(w_t - DIV_W) : w_t[RW-1:0];

  // start wins over a plain step; with a valid bit it becomes the first bit of a new number.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rem    <= '0;
      r_active <= 1'b0;
    end else if (start) begin
      r_rem    <= din_valid ? RW'(din) : '0;
      r_active <= din_valid;
    end else if (din_valid) begin
      r_rem    <= w_next;
      r_active <= 1'b1;
    end
  end

  assign rem    = r_rem;
  assign active = r_active;
  assign dout   = r_active && (r_rem == '0);

endmodule

// File: rtl/mod_n_stream_checker.sv
// CH independent MSB-first divisibility checkers; lane i's remainder is packed
// at rem[i*RW +: RW].
module mod_n_stream_checker
  import mod_n_pkg::*;
#(
  parameter  int DIVISOR = 5,
  parameter  int CH      = 1,
  localparam int RW      = rem_width(DIVISOR)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [CH-1:0]    din_valid,
  input  logic [CH-1:0]    din,
  input  logic [CH-1:0]    start,
  output logic [CH-1:0]    dout,
  output logic [CH*RW-1:0] rem,
  output logic [CH-1:0]    active
);

  // din_valid is a plain qualifier with no backpressure: a lane absorbs din on
  // every edge where its din_valid is high, and outputs update one cycle later.
  for (genvar g = 0; g < CH; g++) begin : g_lane
    mod_n_lane #(
      .DIVISOR(DIVISOR)
    ) u_lane (
      .clk      (clk),
      .resetn   (resetn),
      .din_valid(din_valid[g]),
      .din      (din[g]),
      .start    (start[g]),
      .dout     (dout[g]),
      .rem      (rem[g*RW +: RW]),
      .active   (active[g])
    );
  end

endmodule
